event_monitor_mc: RTL and testbench
===================================

EVENT_MONITOR_MC -- requirements
Module: event_monitor_mc

Interface
REQ-001 SHALL have parameters: NCH, default 4, number of probe channels (2..16); PROBE_W, default 32, probe width; ID_W, default 8, probe id width; TS_W, default 32, timestamp width; FIFO_DEPTH, default 16, event FIFO entries (power of 2, >=2); CH_W, derived, clog2(NCH).
REQ-002 SHALL have ports:
 clk  in  1  single clock; all logic on rising edge.
 rst  in  1  asynchronous, active-high reset.
 en  in  1  enables timestamp counting and triggering.
 arm  in  1  level; triggers accepted only while high.
 clear  in  1  pulse; flushes FIFO, zeroes ts/stickies/counters.
 trig_mode  in  2*NCH  per-channel mode; channel c at [2c+1:2c].
 trig_value  in  PROBE_W*NCH  per-channel compare value.
 trig_mask  in  PROBE_W*NCH  per-channel compare mask.
 probe_id  in  ID_W*NCH  per-channel probe id.
 probe_data  in  PROBE_W*NCH  per-channel probe sample.
 capture_limit  in  16  max events per arm session; 0 = unlimited.
 evt_pop  in  1  pops FIFO head when evt_valid.
 evt_data  out  TS_W+CH_W+ID_W+PROBE_W  FIFO head {ts, ch, id, data}.
 evt_valid  out  1  FIFO non-empty.
 fifo_count  out  clog2(FIFO_DEPTH+1)  occupancy.
 triggered_sticky  out  NCH  per-channel hit-seen flag.
 overflow_sticky  out  1  an event was lost.
 drop_count  out  16  lost events, saturating at 0xFFFF.
 capture_done  out  1  capture_limit reached.

Function
REQ-003 SHALL compute per channel mp = probe & mask, mv = value & mask, mp_d = mp registered every cycle.
REQ-004 SHALL hit per mode: 0 mp==mv; 1 mp_d==0 && mp!=0; 2 mp!=mp_d; 3 disabled.
REQ-005 SHALL qualify hit with en && arm && !capture_done; qualified hit sets triggered_sticky[c].
REQ-006 SHALL capture qualified hit into per-channel holding register {ts, c, id, data} at the same edge; ts is the pre-edge value.
REQ-007 SHALL, if holding[c] valid and not granted this cycle, drop the new hit: holding unchanged, drop_count++, overflow_sticky set.
REQ-008 SHALL, if holding[c] granted in the same cycle a new hit arrives, load the new hit; no drop.
REQ-009 SHALL grant one valid holding register per cycle, round-robin from rr_ptr upward with wrap; rr_ptr <= granted+1 mod NCH after each grant.
REQ-010 SHALL push the granted entry into FIFO at that edge; minimum hit-to-evt_valid latency 2 cycles with empty FIFO and no contention.
REQ-011 SHALL, on grant with FIFO full and no simultaneous pop, discard the entry, clear holding, drop_count++, set overflow_sticky.
REQ-012 SHALL accept push on full FIFO when evt_pop in the same cycle; count unchanged.
REQ-013 SHALL ignore evt_pop when empty; no state change.
REQ-014 SHALL present FIFO head combinationally on evt_data; order is push order.
REQ-015 SHALL increment ts by 1 each cycle en is high, wrapping modulo 2^TS_W.
REQ-016 SHALL count successful FIFO pushes per session; when count == capture_limit != 0, set capture_done and block further qualification. Holding registers still drain.
REQ-017 SHALL start a new session on arm rising edge: session count and capture_done cleared; stickies and FIFO kept.
REQ-018 SHALL give clear priority over all same-cycle activity: FIFO empty, holdings invalid, ts, drop_count, stickies, capture_done, session count, rr_ptr zeroed; mp_d still updates.
REQ-019 SHALL saturate drop_count at 0xFFFF; overflow_sticky still set.

Reset
REQ-020 SHALL, on rst high (asynchronous), force: evt_valid 0, fifo_count 0, evt_data 0, triggered_sticky 0, overflow_sticky 0, drop_count 0, capture_done 0, ts 0, mp_d 0, rr_ptr 0, holdings invalid.
REQ-021 SHALL resume on first clk edge after rst deasserts; rst mid-operation discards all pending and queued events.

Verification
REQ-022 NCH=4, ch0 mode 0 value 0xA5 mask 0xFF, probe 0xA5 at ts=10 -> evt_valid 2 cycles later, evt_data {10, 0, id0, 0xA5}, triggered_sticky=0001.
REQ-023 All 4 channels mode 2 toggled in one cycle at ts=T -> 4 events popped in order ch0..ch3, all ts=T, drop_count 0.
REQ-024 FIFO_DEPTH=4, ch1 mode 2 toggling every cycle, no pops, 8 cycles -> fifo_count 4, overflow_sticky 1, drop_count = accepted hits - 4, first 4 entries intact.
REQ-025 capture_limit=3, continuous ch0 hits -> exactly 3 events, capture_done 1; arm low then high -> capture_done 0, capture resumes.
REQ-026 FIFO full, push and evt_pop same cycle -> fifo_count stays FIFO_DEPTH, overflow_sticky 0; clear with events queued -> next cycle evt_valid 0, ts 0.

Source files
------------

// File: rtl/event_monitor_mc.sv
// event_monitor_mc: multi-channel probe trigger monitor.
// Each channel compares a masked probe sample against a masked value
// (match / rising-from-zero / any-change). A qualified hit is captured into
// a per-channel holding register as {ts, ch, id, data}. Holding registers
// drain one per cycle, round-robin, into a shared event FIFO.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   en, arm, clear             timestamp/trigger enable, arm level, flush pulse
//   trig_mode/value/mask       per-channel trigger configuration
//   probe_id, probe_data       per-channel probe identity and sample
//   capture_limit              events per arm session (0 = unlimited)
//   evt_pop                    pop FIFO head
//   evt_data, evt_valid        FIFO head and non-empty flag
//   fifo_count                 FIFO occupancy
//   triggered_sticky           per-channel hit-seen flags
//   overflow_sticky            an event was lost
//   drop_count                 lost events (saturating)
//   capture_done               session limit reached
module event_monitor_mc #(
   parameter int NCH        = 4,
   parameter int PROBE_W    = 32,
   parameter int ID_W       = 8,
   parameter int TS_W       = 32,
   parameter int FIFO_DEPTH = 16,
   localparam int CH_W      = $clog2(NCH),
   localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             en,
   input  logic                             arm,
   input  logic                             clear,
   input  logic [2*NCH-1:0]                 trig_mode,
   input  logic [PROBE_W*NCH-1:0]           trig_value,
   input  logic [PROBE_W*NCH-1:0]           trig_mask,
   input  logic [ID_W*NCH-1:0]              probe_id,
   input  logic [PROBE_W*NCH-1:0]           probe_data,
   input  logic [15:0]                      capture_limit,
   input  logic                             evt_pop,
   output logic [TS_W+CH_W+ID_W+PROBE_W-1:0] evt_data,
   output logic                             evt_valid,
   output logic [CNT_W-1:0]                 fifo_count,
   output logic [NCH-1:0]                   triggered_sticky,
   output logic                             overflow_sticky,
   output logic [15:0]                      drop_count,
   output logic                             capture_done
);

   localparam int EW = TS_W + CH_W + ID_W + PROBE_W;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [TS_W-1:0]    r_ts;
   logic [PROBE_W-1:0] r_mp_d [NCH];
   logic [NCH-1:0]     r_hold_vld;
   logic [EW-1:0]      r_hold [NCH];
   logic [CH_W-1:0]    r_rr_ptr;
   logic [EW-1:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [NCH-1:0]     r_sticky;
   logic               r_ovf;
   logic [15:0]        r_drop;
   logic               r_done;
   logic [15:0]        r_sess;
   logic               r_arm_d;

   logic [PROBE_W-1:0] w_mp [NCH];
   logic [PROBE_W-1:0] w_mv [NCH];
   logic [EW-1:0]      w_entry [NCH];
   logic [NCH-1:0]     w_hit;
   logic [NCH-1:0]     w_new;
   logic [NCH-1:0]     w_load;
   logic [NCH-1:0]     w_hold_drop;
   logic [NCH-1:0]     w_hold_vld_nxt;
   logic               w_gnt_vld;
   logic [CH_W-1:0]    w_gnt_idx;
   logic               w_pop;
   logic               w_full;
   logic               w_push;
   logic               w_fifo_drop;
   logic               w_arm_rise;
   logic [15:0]        w_sess_nxt;
   logic               w_done_nxt;
   logic               w_qual;
   logic [4:0]         w_drop_inc;
   logic [16:0]        w_drop_sum;

   // Per-channel masked compare and hit detection
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         w_mp[c] = probe_data[c*PROBE_W +: PROBE_W] & trig_mask[c*PROBE_W +: PROBE_W];
         w_mv[c] = trig_value[c*PROBE_W +: PROBE_W] & trig_mask[c*PROBE_W +: PROBE_W];
         w_entry[c] = {r_ts, CH_W'(c), probe_id[c*ID_W +: ID_W], probe_data[c*PROBE_W +: PROBE_W]};
         case (trig_mode[2*c +: 2])
            2'd0:    w_hit[c] = (w_mp[c] == w_mv[c]);
            2'd1:    w_hit[c] = (r_mp_d[c] == '0) && (w_mp[c] != '0);
            2'd2:    w_hit[c] = (w_mp[c] != r_mp_d[c]);
            default: w_hit[c] = 1'b0;
         endcase
      end
   end

   // Round-robin search for the first valid holding register from r_rr_ptr
   always_comb begin
      int v_idx;
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      v_idx     = 0;
      for (int i = 0; i < NCH; i++) begin
         v_idx = int'(r_rr_ptr) + i;
         if (v_idx >= NCH) begin
            v_idx = v_idx - NCH;
         end else begin
            v_idx = v_idx;
         end
         if (!w_gnt_vld && r_hold_vld[v_idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = CH_W'(v_idx);
         end else begin
            w_gnt_vld = w_gnt_vld;
         end
      end
   end

   // FIFO handshake, session accounting and hit qualification.
   // Qualification looks at the post-edge done state so the hit arriving on
   // the same edge as the limit-reaching push is already blocked.
   always_comb begin
      w_pop       = evt_pop && (r_count != '0);
      w_full      = (r_count == CNT_W'(FIFO_DEPTH));
      w_push      = w_gnt_vld && (!w_full || w_pop);
      w_fifo_drop = w_gnt_vld && w_full && !w_pop;
      w_arm_rise  = arm && !r_arm_d;
      w_sess_nxt  = (w_arm_rise ? 16'd0 : r_sess) + {15'd0, w_push};
      w_done_nxt  = (r_done && !w_arm_rise) ||
                    ((capture_limit != 16'd0) && (w_sess_nxt == capture_limit));
      w_qual      = en && arm && !w_done_nxt;
   end

   // Holding register load/drop decisions and total lost-event count
   always_comb begin
      w_drop_inc = {4'd0, w_fifo_drop};
      for (int c = 0; c < NCH; c++) begin
         w_new[c]          = w_hit[c] && w_qual;
         w_load[c]         = w_new[c] && (!r_hold_vld[c] || (w_gnt_vld && (w_gnt_idx == CH_W'(c))));
         w_hold_drop[c]    = w_new[c] && r_hold_vld[c] && !(w_gnt_vld && (w_gnt_idx == CH_W'(c)));
         w_hold_vld_nxt[c] = w_load[c] || (r_hold_vld[c] && !(w_gnt_vld && (w_gnt_idx == CH_W'(c))));
         w_drop_inc        = w_drop_inc + {4'd0, w_hold_drop[c]};
      end
      w_drop_sum = {1'b0, r_drop} + {12'd0, w_drop_inc};
   end

   // Masked probe history; updated every cycle, clear does not touch it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) r_mp_d[c] <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) r_mp_d[c] <= w_mp[c];
      end
   end

   // Arm level history for session-start detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_arm_d <= 1'b0;
      else     r_arm_d <= arm;
   end

   // Holding register valid flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_hold_vld <= '0;
      else if (clear) r_hold_vld <= '0;
      else            r_hold_vld <= w_hold_vld_nxt;
   end

   // Holding register payloads (qualified by the valid flags)
   always_ff @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (w_load[c]) r_hold[c] <= w_entry[c];
      end
   end

   // FIFO storage; head is masked when empty
   always_ff @(posedge clk) begin
      if (!clear && w_push) r_mem[r_wr_ptr] <= r_hold[w_gnt_idx];
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst || clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Timestamp, stickies, drop counter, session state and arbitration pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst || clear) begin
         r_ts     <= '0;
         r_sticky <= '0;
         r_ovf    <= 1'b0;
         r_drop   <= 16'd0;
         r_done   <= 1'b0;
         r_sess   <= 16'd0;
         r_rr_ptr <= '0;
      end else begin
         if (en) r_ts <= r_ts + TS_W'(1);
         r_sticky <= r_sticky | w_new;
         if (w_drop_inc != 5'd0) begin
            r_ovf  <= 1'b1;
            r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
         end
         r_done <= w_done_nxt;
         r_sess <= w_sess_nxt;
         if (w_gnt_vld) begin
            r_rr_ptr <= (w_gnt_idx == CH_W'(NCH - 1)) ? '0 : (w_gnt_idx + CH_W'(1));
         end
      end
   end

   assign evt_valid        = (r_count != '0);
   assign evt_data         = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
   assign fifo_count       = r_count;
   assign triggered_sticky = r_sticky;
   assign overflow_sticky  = r_ovf;
   assign drop_count       = r_drop;
   assign capture_done     = r_done;

endmodule

// File: tb/tb_event_monitor_mc.sv
module tb_event_monitor_mc;
   localparam int NCH = 4, PW = 8, IW = 8, TW = 16, DEPTH = 4, CW = 2, EW = TW + CW + IW + PW;

   logic clk = 1'b0, rst = 1'b1, en = 1'b0, arm = 1'b0, clear = 1'b0, evt_pop = 1'b0;
   logic [2*NCH-1:0]  trig_mode = 8'hFF;
   logic [PW*NCH-1:0] trig_value = 32'd0, trig_mask = 32'd0, probe_data = 32'd0;
   logic [IW*NCH-1:0] probe_id = 32'h44332211;
   logic [15:0]       capture_limit = 16'd0;
   logic [EW-1:0]     evt_data;
   logic              evt_valid, overflow_sticky, capture_done;
   logic [2:0]        fifo_count;
   logic [NCH-1:0]    triggered_sticky;
   logic [15:0]       drop_count;

   event_monitor_mc #(.NCH(NCH), .PROBE_W(PW), .ID_W(IW), .TS_W(TW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .en(en), .arm(arm), .clear(clear),
      .trig_mode(trig_mode), .trig_value(trig_value), .trig_mask(trig_mask),
      .probe_id(probe_id), .probe_data(probe_data), .capture_limit(capture_limit),
      .evt_pop(evt_pop), .evt_data(evt_data), .evt_valid(evt_valid),
      .fifo_count(fifo_count), .triggered_sticky(triggered_sticky),
      .overflow_sticky(overflow_sticky), .drop_count(drop_count), .capture_done(capture_done));

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;

   // Reference model state: queue-based FIFO, one pending slot per channel
   logic [EW-1:0] m_q[$];
   logic [EW-1:0] m_hold[NCH];
   bit            m_hold_v[NCH];
   logic [PW-1:0] m_mpd[NCH];
   int            m_rr, m_sess, m_drop;
   logic [TW-1:0] m_ts;
   logic [NCH-1:0] m_sticky;
   bit            m_ovf, m_done, m_arm_d;
   logic [EW-1:0] dut_pops[$];

   task automatic m_reset();
      m_q.delete();
      for (int c = 0; c < NCH; c++) begin m_hold_v[c] = 0; m_mpd[c] = '0; m_hold[c] = '0; end
      m_rr = 0; m_sess = 0; m_drop = 0; m_ts = '0; m_sticky = '0;
      m_ovf = 0; m_done = 0; m_arm_d = 0;
   endtask

   task automatic m_clear();
      m_q.delete();
      for (int c = 0; c < NCH; c++) m_hold_v[c] = 0;
      m_rr = 0; m_sess = 0; m_drop = 0; m_ts = '0; m_sticky = '0; m_ovf = 0; m_done = 0;
   endtask

   // Predict the state after the coming rising edge from the current inputs
   task automatic model_step();
      logic [PW-1:0] mp[NCH];
      logic [PW-1:0] mv;
      bit hit[NCH];
      bit arm_rise, pop, gv, push, done_n, qual;
      int g, drops, sess_n;
      for (int c = 0; c < NCH; c++) begin
         mp[c] = probe_data[c*PW +: PW] & trig_mask[c*PW +: PW];
         mv    = trig_value[c*PW +: PW] & trig_mask[c*PW +: PW];
         case (trig_mode[2*c +: 2])
            2'd0:    hit[c] = (mp[c] == mv);
            2'd1:    hit[c] = (m_mpd[c] == 0) && (mp[c] != 0);
            2'd2:    hit[c] = (mp[c] != m_mpd[c]);
            default: hit[c] = 0;
         endcase
      end
      arm_rise = arm && !m_arm_d;
      pop = evt_pop && (m_q.size() > 0);
      gv = 0; g = 0;
      for (int i = 0; i < NCH; i++) begin
         int k;
         k = (m_rr + i) % NCH;
         if (!gv && m_hold_v[k]) begin gv = 1; g = k; end
      end
      push = gv && ((m_q.size() < DEPTH) || pop);
      sess_n = (arm_rise ? 0 : m_sess) + (push ? 1 : 0);
      done_n = (capture_limit != 0 && sess_n == int'(capture_limit)) ? 1 : (m_done && !arm_rise);
      qual = en && arm && !done_n;
      for (int c = 0; c < NCH; c++) m_mpd[c] = mp[c];
      m_arm_d = arm;
      if (clear) begin
         m_clear();
         return;
      end
      drops = 0;
      if (pop) void'(m_q.pop_front());
      if (gv) begin
         if (push) m_q.push_back(m_hold[g]);
         else drops++;
         m_hold_v[g] = 0;
         m_rr = (g + 1) % NCH;
      end
      for (int c = 0; c < NCH; c++) begin
         if (qual && hit[c]) begin
            m_sticky[c] = 1'b1;
            if (m_hold_v[c]) drops++;
            else begin
               m_hold_v[c] = 1;
               m_hold[c] = {m_ts, 2'(c), probe_id[c*IW +: IW], probe_data[c*PW +: PW]};
            end
         end
      end
      m_sess = sess_n;
      m_done = done_n;
      if (drops > 0) begin
         m_ovf = 1;
         m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
      end
      if (en) m_ts = m_ts + 16'd1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [EW-1:0] head;
      head = (m_q.size() > 0) ? m_q[0] : '0;
      chk("evt_valid", 64'(evt_valid), 64'(m_q.size() > 0));
      chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
      chk("evt_data", 64'(evt_data), 64'(head));
      chk("triggered_sticky", 64'(triggered_sticky), 64'(m_sticky));
      chk("overflow_sticky", 64'(overflow_sticky), 64'(m_ovf));
      chk("drop_count", 64'(drop_count), 64'(m_drop));
      chk("capture_done", 64'(capture_done), 64'(m_done));
   endtask

   // One clock: predict, record DUT pops, advance, compare
   task automatic cycle();
      model_step();
      if (evt_pop && evt_valid) dut_pops.push_back(evt_data);
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      logic [TW-1:0] t_req;
      int guard;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      rst = 1'b0; en = 1'b1; arm = 1'b1;

      // Single match on ch0 at ts=10
      trig_mode = 8'hFC; trig_value = 32'h000000A5; trig_mask = 32'h000000FF;
      guard = 0;
      while (m_ts != 16'd10 && guard < 40) begin cycle(); guard++; end
      chk("ts10_reached", 64'(guard), 64'd10);
      probe_data = 32'h000000A5; cycle();
      probe_data = 32'h0; cycle();
      chk("match_valid", 64'(evt_valid), 64'd1);
      chk("match_data", 64'(evt_data), 64'({16'd10, 2'd0, 8'h11, 8'hA5}));
      chk("match_sticky", 64'(triggered_sticky), 64'h1);
      evt_pop = 1'b1; cycle(); evt_pop = 1'b0;

      // All channels change in one cycle; drained in channel order
      clear = 1'b1; cycle(); clear = 1'b0;
      trig_mode = 8'hAA; trig_mask = 32'hFFFFFFFF; cycle();
      t_req = m_ts;
      probe_data = 32'hFFFFFFFF;
      repeat (6) cycle();
      chk("allch_count", 64'(fifo_count), 64'd4);
      dut_pops.delete(); evt_pop = 1'b1; repeat (4) cycle(); evt_pop = 1'b0;
      chk("allch_npop", 64'(dut_pops.size()), 64'd4);
      for (int i = 0; i < dut_pops.size(); i++) begin
         chk("allch_ch", 64'(dut_pops[i][17:16]), 64'(i));
         chk("allch_ts", 64'(dut_pops[i][33:18]), 64'(t_req));
      end
      chk("allch_drop", 64'(drop_count), 64'd0);

      // ch1 toggling every cycle into a 4-deep FIFO with no pops
      trig_mode = 8'hFB; clear = 1'b1; cycle(); clear = 1'b0;
      t_req = m_ts;
      for (int i = 0; i < 8; i++) begin probe_data[15:8] = ~probe_data[15:8]; cycle(); end
      chk("ovf_count", 64'(fifo_count), 64'd4);
      chk("ovf_sticky", 64'(overflow_sticky), 64'd1);
      chk("ovf_drop", 64'(drop_count), 64'd3);
      dut_pops.delete(); evt_pop = 1'b1; repeat (4) cycle(); evt_pop = 1'b0;
      for (int i = 0; i < dut_pops.size(); i++) begin
         chk("ovf_ts", 64'(dut_pops[i][33:18]), 64'(t_req + 16'(i)));
         chk("ovf_data", 64'(dut_pops[i][7:0]), (i % 2 == 0) ? 64'h00 : 64'hFF);
      end

      // Capture limit of 3 with continuous ch0 hits, then re-arm
      trig_mode = 8'hFC; trig_mask = 32'hFFFFFF00; capture_limit = 16'd3;
      clear = 1'b1; cycle(); clear = 1'b0;
      dut_pops.delete(); evt_pop = 1'b1;
      repeat (10) cycle();
      chk("limit_events", 64'(dut_pops.size()), 64'd3);
      chk("limit_done", 64'(capture_done), 64'd1);
      arm = 1'b0; repeat (3) cycle();
      dut_pops.delete(); arm = 1'b1; cycle();
      chk("rearm_done", 64'(capture_done), 64'd0);
      repeat (10) cycle();
      chk("rearm_events", 64'(dut_pops.size()), 64'd3);
      chk("rearm_done2", 64'(capture_done), 64'd1);
      evt_pop = 1'b0; capture_limit = 16'd0;

      // Full FIFO with simultaneous push and pop, then clear with events queued
      trig_mode = 8'hFB; trig_mask = 32'hFFFFFFFF;
      clear = 1'b1; cycle(); clear = 1'b0;
      for (int i = 0; i < 5; i++) begin probe_data[15:8] = ~probe_data[15:8]; cycle(); end
      chk("full_count", 64'(fifo_count), 64'd4);
      evt_pop = 1'b1; cycle(); evt_pop = 1'b0;
      chk("pushpop_count", 64'(fifo_count), 64'd4);
      chk("pushpop_ovf", 64'(overflow_sticky), 64'd0);
      clear = 1'b1; cycle(); clear = 1'b0;
      chk("clear_valid", 64'(evt_valid), 64'd0);
      probe_data[15:8] = ~probe_data[15:8]; cycle(); cycle();
      chk("clear_ts0_valid", 64'(evt_valid), 64'd1);
      chk("clear_ts0", 64'(evt_data[33:18]), 64'd0);

      // Asynchronous reset with events queued
      probe_data[15:8] = ~probe_data[15:8]; cycle(); cycle();
      rst = 1'b1; #2;
      m_reset();
      chk("rst_valid", 64'(evt_valid), 64'd0);
      chk("rst_count", 64'(fifo_count), 64'd0);
      chk("rst_data", 64'(evt_data), 64'd0);
      chk("rst_sticky", 64'(triggered_sticky), 64'd0);
      @(posedge clk); #1; rst = 1'b0;

      // Randomized traffic against the model
      for (int n = 0; n < 800; n++) begin
         if (n % 50 == 0) begin
            trig_mode  = 8'($urandom);
            trig_mask  = ($urandom_range(0, 1) == 0) ? 32'h03030303 : $urandom;
            trig_value = $urandom & 32'h03030303;
            capture_limit = 16'($urandom_range(0, 6));
         end
         probe_data = $urandom & 32'h03030303;
         evt_pop = ($urandom_range(0, 3) != 0);
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 39) == 0) arm = ~arm;
         clear = ($urandom_range(0, 99) == 0);
         cycle();
      end
      clear = 1'b0; evt_pop = 1'b0; en = 1'b1; arm = 1'b1; capture_limit = 16'd0;

      // Drop counter saturation: every channel toggling, nothing popped
      trig_mode = 8'hAA; trig_mask = 32'hFFFFFFFF;
      clear = 1'b1; cycle(); clear = 1'b0;
      repeat (17000) begin probe_data = ~probe_data; cycle(); end
      chk("sat_drop", 64'(drop_count), 64'hFFFF);
      chk("sat_ovf", 64'(overflow_sticky), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
